// File: rtl/multi_timer_if.sv
// Register-decoder side bundle for multi_timer: shared write data, per-register
// strobes and read lines, plus the combined interrupt request.
interface multi_timer_if #(
   parameter int CHANNELS = 4
);
   localparam int REGS = 3 * CHANNELS + 2;

   logic [31:0]            data_in;
   logic [REGS-1:0][31:0]  data_out;
   logic [REGS-1:0]        write_en;
   logic [REGS-1:0]        read_en;
   logic                   irq_out;

   modport master (
      output data_in,
      output write_en,
      output read_en,
      input  data_out,
      input  irq_out
   );

   modport slave (
      input  data_in,
      input  write_en,
      input  read_en,
      output data_out,
      output irq_out
   );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel up/down timer with reload/compare, one-shot and sticky W1C pending flags.
// Optional tick prescaler is built only when MULTI_TIMER_PRESCALE_EN is defined.
module multi_timer #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32
) (
   input  logic          clk,
   input  logic          reset,
   multi_timer_if.slave  bus
);
   localparam int REGS       = 3 * CHANNELS + 2;
   localparam int STATUS_IDX = 3 * CHANNELS;
   localparam int PRESC_IDX  = 3 * CHANNELS + 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic                tick;
   logic [CHANNELS-1:0] pend_vec;
   logic [CHANNELS-1:0] ire_vec;
   logic                irq_q, irq_d;
   logic                unused_bits;

   // read_en carries no side effects; only the low data bits matter per register.
   assign unused_bits = ^{bus.read_en, bus.data_in};

`ifdef MULTI_TIMER_PRESCALE_EN
   logic [15:0] presc_q, presc_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        we_presc;

   assign we_presc = bus.write_en[PRESC_IDX];

   always_comb begin
      presc_d = we_presc ? bus.data_in[15:0] : presc_q;
      tick    = (pcnt_q == presc_q);
      if (we_presc || tick) begin
         pcnt_d = 16'd0;
      end else begin
         pcnt_d = pcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= 16'd0;
         pcnt_q  <= 16'd0;
      end else begin
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
      end
   end

   assign bus.data_out[PRESC_IDX] = 32'(presc_q);
`else
   assign tick                    = 1'b1;
   assign bus.data_out[PRESC_IDX] = 32'd0;
`endif

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [WIDTH-1:0] count_q, count_d;
      logic [WIDTH-1:0] reload_q, reload_d;
      logic [WIDTH-1:0] adv_val;
      logic [4:0]       cfg_q, cfg_d;
      logic             pend_q, pend_d;
      logic             we_cnt, we_rld, we_cfg, clr;
      logic             term, adv, evt;

      assign we_cnt = bus.write_en[3*n];
      assign we_rld = bus.write_en[3*n+1];
      assign we_cfg = bus.write_en[3*n+2];
      assign clr    = bus.write_en[STATUS_IDX] & bus.data_in[n];

      // cfg_q bits: 0 EN, 1 DIR(up), 2 MODE(periodic), 3 IRE, 4 ONESHOT
      always_comb begin
         term = cfg_q[1] ? (count_q == reload_q) : (count_q == '0);
         adv  = cfg_q[0] & tick;
         evt  = adv & term & ~we_cnt;

         if (term && cfg_q[2]) begin
            adv_val = cfg_q[1] ? '0 : reload_q;
         end else begin
            adv_val = cfg_q[1] ? (count_q + ONE) : (count_q - ONE);
         end

         if (we_cnt) begin
            count_d = bus.data_in[WIDTH-1:0];
         end else if (adv) begin
            count_d = adv_val;
         end else begin
            count_d = count_q;
         end

         reload_d = we_rld ? bus.data_in[WIDTH-1:0] : reload_q;

         // A software CONFIG write overrides the one-shot auto-disable.
         cfg_d = cfg_q;
         if (evt && cfg_q[4]) begin
            cfg_d[0] = 1'b0;
         end
         if (we_cfg) begin
            cfg_d = bus.data_in[4:0];
         end

         if (evt) begin
            pend_d = 1'b1;
         end else if (clr) begin
            pend_d = 1'b0;
         end else begin
            pend_d = pend_q;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            cfg_q    <= 5'd0;
            pend_q   <= 1'b0;
         end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            cfg_q    <= cfg_d;
            pend_q   <= pend_d;
         end
      end

      assign pend_vec[n] = pend_q;
      assign ire_vec[n]  = cfg_q[3];

      assign bus.data_out[3*n]   = 32'(count_q);
      assign bus.data_out[3*n+1] = 32'(reload_q);
      assign bus.data_out[3*n+2] = 32'(cfg_q);
   end

   assign bus.data_out[STATUS_IDX] = 32'(pend_vec);

   assign irq_d = |(pend_vec & ire_vec);

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign bus.irq_out = irq_q;

   if (REGS != 3 * CHANNELS + 2) begin : g_bad_regs
      $error("multi_timer: REGS must equal 3*CHANNELS+2");
   end
endmodule
